// File: rtl/proc_run_controller_pkg.sv
// Shared types and default constants for the processor run/start controller.
// The state encoding is visible on state_o, so its values are fixed here.
package proc_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_HOLD    = 3'd0,
    S_IDLE    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } run_state_t;

  localparam int DEF_N_CORES         = 1;
  localparam int DEF_RST_CYCLES      = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_CNT_W           = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 0;

endpackage

// File: rtl/proc_run_controller_switch_debounce.sv
// Start-switch conditioning: 2-flop synchroniser, run-length debounce and
// rising-edge detect. Emits a one-cycle start event per accepted press.
module switch_debounce
  import proc_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_switch,
  output logic o_start_evt
);

  localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_prev;
  logic             r_vld1;
  logic             r_vld2;
  logic [RUN_W-1:0] r_run_len;
  logic [RUN_W-1:0] w_run_len;
  logic             w_stable;
  logic             r_level;
  logic             r_level_d;
  logic             r_level_vld;
  logic             r_armed;

  // The valid pipe keeps post-reset zeros in the synchroniser from being
  // counted as genuine low samples of the switch.
  always_comb begin
    w_run_len = '0;
    if (r_vld2) begin
      if (r_sync2 != r_sync_prev) begin
        w_run_len = RUN_W'(1);
      end else if (r_run_len == RUN_FULL) begin
        w_run_len = r_run_len;
      end else begin
        w_run_len = r_run_len + 1'b1;
      end
    end
  end

  assign w_stable = (w_run_len == RUN_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
      r_vld1      <= 1'b0;
      r_vld2      <= 1'b0;
      r_run_len   <= '0;
      r_level     <= 1'b0;
      r_level_d   <= 1'b0;
      r_level_vld <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sync1     <= i_switch;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_vld1      <= 1'b1;
      r_vld2      <= r_vld1;
      r_run_len   <= w_run_len;
      if (w_stable) begin
        r_level     <= r_sync2;
        r_level_vld <= 1'b1;
      end
      r_level_d <= r_level;
      r_armed   <= r_level_vld;
    end
  end

  // The first accepted level after reset only arms the detector, so a
  // switch held high through reset must be released and pressed again.
  assign o_start_evt = r_level & ~r_level_d & r_armed;

endmodule

// File: rtl/proc_run_controller.sv
// Run/start controller for an array of processor cores: reset stretch,
// debounced start, one-cycle start pulse, run-cycle count, done/timeout.
module proc_run_controller
  import proc_run_pkg::*;
#(
  parameter int N_CORES         = DEF_N_CORES,
  parameter int RST_CYCLES      = DEF_RST_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               switchStart,
  input  logic [N_CORES-1:0] core_en,
  input  logic [N_CORES-1:0] core_done,
  output logic [N_CORES-1:0] core_rst,
  output logic [N_CORES-1:0] core_start,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               run_done,
  output logic               run_timeout
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit                TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

  run_state_t         r_state;
  run_state_t         w_state_next;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic [N_CORES-1:0] r_en_q;
  logic [N_CORES-1:0] w_en_q_next;
  logic [N_CORES-1:0] r_done_sticky;
  logic [N_CORES-1:0] w_done_sticky_next;
  logic [N_CORES-1:0] r_core_start;
  logic [N_CORES-1:0] w_core_start_next;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   w_cycle_cnt_next;
  logic [CNT_W-1:0]   w_cycle_cnt_inc;
  logic [N_CORES-1:0] w_done_seen;
  logic               w_timeout_hit;
  logic               w_start_evt;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_switch   (switchStart),
    .o_start_evt(w_start_evt)
  );

  // Done pulses landing this cycle count toward completion immediately.
  assign w_done_seen     = r_done_sticky | (core_done & r_en_q);
  assign w_cycle_cnt_inc = (r_cycle_cnt == {CNT_W{1'b1}}) ? r_cycle_cnt
                                                          : r_cycle_cnt + 1'b1;
  assign w_timeout_hit   = TIMEOUT_EN && (r_cycle_cnt == TIMEOUT_LAST);

  always_comb begin
    w_state_next       = r_state;
    w_hold_cnt_next    = r_hold_cnt;
    w_en_q_next        = r_en_q;
    w_done_sticky_next = r_done_sticky;
    w_cycle_cnt_next   = r_cycle_cnt;
    w_core_start_next  = '0;
    case (r_state)
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_next    = S_IDLE;
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (w_start_evt && (core_en != '0)) begin
          w_state_next       = S_RUN;
          w_en_q_next        = core_en;
          w_done_sticky_next = '0;
          w_cycle_cnt_next   = '0;
          w_core_start_next  = core_en;
        end
      end
      S_RUN: begin
        w_cycle_cnt_next   = w_cycle_cnt_inc;
        w_done_sticky_next = w_done_seen;
        if (w_done_seen == r_en_q) begin
          w_state_next = S_DONE;
        end else if (w_timeout_hit) begin
          w_state_next = S_TIMEOUT;
        end
      end
      S_DONE, S_TIMEOUT: begin
        if (w_start_evt) begin
          w_state_next    = S_HOLD;
          w_hold_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = S_HOLD;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_HOLD;
      r_hold_cnt    <= '0;
      r_en_q        <= '0;
      r_done_sticky <= '0;
      r_cycle_cnt   <= '0;
      r_core_start  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_hold_cnt    <= w_hold_cnt_next;
      r_en_q        <= w_en_q_next;
      r_done_sticky <= w_done_sticky_next;
      r_cycle_cnt   <= w_cycle_cnt_next;
      r_core_start  <= w_core_start_next;
    end
  end

  assign core_rst    = {N_CORES{r_state == S_HOLD}};
  assign core_start  = r_core_start;
  assign state_o     = r_state;
  assign cycle_count = r_cycle_cnt;
  assign run_done    = (r_state == S_DONE);
  assign run_timeout = (r_state == S_TIMEOUT);

endmodule

// File: tb/tb_proc_run_controller.sv
// Self-checking bench for proc_run_controller: table-driven runs, randomized
// runs against a completion-time model, and hand-written corner sequences.
module tb_proc_run_controller;

  localparam int TMO = 50;
  localparam int ST_HOLD = 0, ST_IDLE = 1, ST_RUN = 2, ST_DONE = 3, ST_TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        switchStart;
  logic [3:0]  core_en;
  logic [3:0]  core_done;
  logic [3:0]  core_rst, core_start;
  logic [2:0]  state_o;
  logic [31:0] cycle_count;
  logic        run_done, run_timeout;
  logic [3:0]  s_core_rst, s_core_start;
  logic [2:0]  s_state_o;
  logic [3:0]  s_cycle_count;
  logic        s_run_done, s_run_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  proc_run_controller #(
    .N_CORES(4), .RST_CYCLES(4), .DEBOUNCE_CYCLES(3), .CNT_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .switchStart(switchStart), .core_en(core_en),
    .core_done(core_done), .core_rst(core_rst), .core_start(core_start),
    .state_o(state_o), .cycle_count(cycle_count), .run_done(run_done),
    .run_timeout(run_timeout)
  );

  proc_run_controller #(
    .N_CORES(4), .RST_CYCLES(4), .DEBOUNCE_CYCLES(3), .CNT_W(4), .TIMEOUT_CYCLES(0)
  ) dut_sat (
    .clk(clk), .rst(rst), .switchStart(switchStart), .core_en(core_en),
    .core_done(core_done), .core_rst(s_core_rst), .core_start(s_core_start),
    .state_o(s_state_o), .cycle_count(s_cycle_count), .run_done(s_run_done),
    .run_timeout(s_run_timeout)
  );

  typedef struct {
    logic [3:0]  en;
    logic [31:0] times;   // {t3,t2,t1,t0}: run cycle of each done pulse, FF = never
    int          exp_state;
    int          exp_count;
  } run_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Run ends when the last enabled core reports done, one count later;
  // otherwise the timeout fires with the count equal to the limit.
  function automatic void model(input logic [3:0] en, input logic [31:0] times,
                                output int st, output int cnt);
    int max_t;
    int t;
    max_t = -1;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        t = (times[8*i +: 8] == 8'hFF) ? 100000 : int'(times[8*i +: 8]);
        if (t > max_t) max_t = t;
      end
    end
    if (max_t < TMO) begin
      st  = ST_DONE;
      cnt = max_t + 1;
    end else begin
      st  = ST_TMO;
      cnt = TMO;
    end
  endfunction

  task automatic wait_state(input string name, input int st, input int budget);
    int n;
    n = 0;
    while (int'(state_o) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state_o), 32'(st));
  endtask

  task automatic press_and_wait_start(input string name, input logic [3:0] en);
    int lat;
    core_en = en;
    switchStart = 1'b1;
    lat = 0;
    while (core_start == 4'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "/start_latency"}, 32'(lat), 32'd6);
    check({name, "/start_mask"}, 32'(core_start), 32'(en));
  endtask

  task automatic restart(input string name);
    int hold_len;
    switchStart = 1'b1;
    wait_state({name, "/enter_hold"}, ST_HOLD, 20);
    check({name, "/core_rst_hold"}, 32'(core_rst), 32'hF);
    hold_len = 0;
    while (int'(state_o) == ST_HOLD && hold_len < 20) begin
      hold_len++;
      @(negedge clk);
    end
    check({name, "/hold_len"}, 32'(hold_len), 32'd4);
    check({name, "/core_rst_idle"}, 32'(core_rst), 32'h0);
    switchStart = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_run(input string name, input logic [3:0] en, input logic [31:0] times,
                        input int exp_state, input int exp_count);
    int k;
    wait_state({name, "/idle"}, ST_IDLE, 20);
    repeat (4) @(negedge clk);
    press_and_wait_start(name, en);
    check({name, "/count_start"}, cycle_count, 32'd0);
    check({name, "/run_state"}, 32'(state_o), 32'(ST_RUN));
    core_en = ~en;
    k = 0;
    while (k < 200) begin
      for (int i = 0; i < 4; i++) core_done[i] = (times[8*i +: 8] == 8'(k));
      @(negedge clk);
      k++;
      if (k == 1) check({name, "/start_one_cycle"}, 32'(core_start), 32'h0);
      if (int'(state_o) == ST_DONE || int'(state_o) == ST_TMO) break;
    end
    core_done = 4'b0;
    check({name, "/end_state"}, 32'(state_o), 32'(exp_state));
    check({name, "/end_count"}, cycle_count, 32'(exp_count));
    check({name, "/run_done"}, 32'(run_done), 32'(exp_state == ST_DONE));
    check({name, "/run_timeout"}, 32'(run_timeout), 32'(exp_state == ST_TMO));
    repeat (3) @(negedge clk);
    check({name, "/count_frozen"}, cycle_count, 32'(exp_count));
    $display("run %s en=%b times=%h state=%0d count=%0d", name, en, times, state_o, cycle_count);
    switchStart = 1'b0;
    repeat (8) @(negedge clk);
    restart({name, "/restart"});
  endtask

  initial begin
    run_vec_t    vecs[6];
    int          hold_len;
    int          k;
    int          exp_st, exp_cnt;
    logic        seen;
    logic [3:0]  r_en;
    logic [31:0] r_times;

    vecs[0] = '{4'b0101, 32'hFF_14_05_0A, ST_DONE, 21};
    vecs[1] = '{4'b1111, 32'hFF_FF_FF_FF, ST_TMO,  50};
    vecs[2] = '{4'b0001, 32'hFF_FF_FF_31, ST_DONE, 50};
    vecs[3] = '{4'b1000, 32'h00_FF_FF_FF, ST_DONE, 1};
    vecs[4] = '{4'b0110, 32'hFF_32_1E_03, ST_TMO,  50};
    vecs[5] = '{4'b0011, 32'hFF_FF_07_07, ST_DONE, 8};

    rst = 1'b1; switchStart = 1'b0; core_en = 4'b0; core_done = 4'b0;
    @(negedge clk); @(negedge clk);
    check("rst/core_rst", 32'(core_rst), 32'hF);
    check("rst/state", 32'(state_o), 32'(ST_HOLD));
    check("rst/count", cycle_count, 32'd0);
    check("rst/core_start", 32'(core_start), 32'h0);
    check("rst/run_done", 32'(run_done), 32'd0);
    check("rst/run_timeout", 32'(run_timeout), 32'd0);
    rst = 1'b0;
    hold_len = 0;
    while (int'(state_o) == ST_HOLD && hold_len < 20) begin
      hold_len++;
      @(negedge clk);
    end
    check("rst/hold_len", 32'(hold_len), 32'd4);
    check("rst/idle_state", 32'(state_o), 32'(ST_IDLE));
    check("rst/idle_core_rst", 32'(core_rst), 32'h0);

    // Two-cycle glitch must not start a run.
    repeat (4) @(negedge clk);
    core_en = 4'b0101;
    switchStart = 1'b1;
    repeat (2) @(negedge clk);
    switchStart = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= |core_start;
    end
    check("glitch/no_start", 32'(seen), 32'd0);
    check("glitch/state", 32'(state_o), 32'(ST_IDLE));

    // Timeout on the main instance; the 4-bit counter instance saturates.
    press_and_wait_start("sat", 4'b1111);
    k = 0;
    while (!(int'(state_o) == ST_DONE || int'(state_o) == ST_TMO) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("sat/main_state", 32'(state_o), 32'(ST_TMO));
    check("sat/main_count", cycle_count, 32'd50);
    check("sat/narrow_count", 32'(s_cycle_count), 32'd15);
    check("sat/narrow_state", 32'(s_state_o), 32'(ST_RUN));
    $display("run sat main_count=%0d narrow_count=%0d", cycle_count, s_cycle_count);
    switchStart = 1'b0;
    repeat (8) @(negedge clk);
    restart("sat/restart");

    for (int v = 0; v < 6; v++) begin
      do_run($sformatf("vec%0d", v), vecs[v].en, vecs[v].times, vecs[v].exp_state, vecs[v].exp_count);
    end

    for (int r = 0; r < 6; r++) begin
      r_en = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) begin
        r_times[8*i +: 8] = ($urandom_range(9, 0) == 0) ? 8'hFF : 8'($urandom_range(55, 0));
      end
      model(r_en, r_times, exp_st, exp_cnt);
      do_run($sformatf("rand%0d", r), r_en, r_times, exp_st, exp_cnt);
    end

    // Empty enable mask at the press is ignored.
    repeat (4) @(negedge clk);
    core_en = 4'b0;
    switchStart = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= |core_start;
    end
    check("no_en/no_start", 32'(seen), 32'd0);
    check("no_en/state", 32'(state_o), 32'(ST_IDLE));
    switchStart = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-run with the switch held high.
    press_and_wait_start("midrst", 4'b1111);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/core_rst", 32'(core_rst), 32'hF);
    check("midrst/state", 32'(state_o), 32'(ST_HOLD));
    check("midrst/count", cycle_count, 32'd0);
    check("midrst/core_start", 32'(core_start), 32'h0);
    check("midrst/run_done", 32'(run_done), 32'd0);
    rst = 1'b0;
    wait_state("midrst/idle", ST_IDLE, 20);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= |core_start;
    end
    check("midrst/held_no_start", 32'(seen), 32'd0);
    check("midrst/held_state", 32'(state_o), 32'(ST_IDLE));
    switchStart = 1'b0;
    repeat (8) @(negedge clk);
    do_run("post_rst", 4'b0001, 32'hFF_FF_FF_02, ST_DONE, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
